// File: rtl/redp_adc_if.sv
`default_nettype none
// ============================================================================
//  Module   : redp_adc_if
//  Purpose  : Bundles the raw ADC pins, controls and result bus of redp_adc.
//             The slave modport is the converter's view of the bundle.
//  Revision : 1.0 - first release
// ============================================================================
interface redp_adc_if #(
  parameter int ADC_WIDTH = 14
);
  logic [ADC_WIDTH-1:0] adc_dat_a_i;
  logic [ADC_WIDTH-1:0] adc_dat_b_i;
  logic                 en_i;
  logic                 ovr_clr_i;
  logic [15:0]          adc_dat_a_o;
  logic [15:0]          adc_dat_b_o;
  logic                 adc_valid_o;
  logic                 ovr_a_o;
  logic                 ovr_b_o;
  logic                 adc_cdcs_o;

  modport master (
    output adc_dat_a_i, adc_dat_b_i, en_i, ovr_clr_i,
    input  adc_dat_a_o, adc_dat_b_o, adc_valid_o, ovr_a_o, ovr_b_o, adc_cdcs_o
  );

  modport slave (
    input  adc_dat_a_i, adc_dat_b_i, en_i, ovr_clr_i,
    output adc_dat_a_o, adc_dat_b_o, adc_valid_o, ovr_a_o, ovr_b_o, adc_cdcs_o
  );
endinterface
`default_nettype wire

// File: rtl/redp_adc.sv
`default_nettype none
// ============================================================================
//  Module   : redp_adc
//  Purpose  : Dual-channel ADC front end. Registers the raw pins, converts
//             inverted offset binary to two's complement, drops a settling
//             window after enable, then averages 2^DEC_LOG2 samples per
//             output strobe. Sticky per-channel overrange flags.
//  Revision : 1.0 - first release
// ============================================================================
module redp_adc #(
  parameter int ADC_WIDTH = 14,
  parameter int DEC_LOG2  = 0,
  parameter int DISCARD   = 16
) (
  input  logic        adc_clk,
  input  logic        adc_rst_n,
  redp_adc_if.slave   bus
);

  localparam int ACC_W = ADC_WIDTH + DEC_LOG2;
  localparam int CNT_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << DEC_LOG2) - 1);
  localparam logic [7:0]       DISC_LAST = 8'(DISCARD - 1);
  localparam logic signed [ADC_WIDTH-1:0] S2_MAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic signed [ADC_WIDTH-1:0] S2_MIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DISCARD = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        [ADC_WIDTH-1:0] raw_a, raw_b;
  logic signed [ADC_WIDTH-1:0] s2_a, s2_b;
  logic signed [ACC_W-1:0]     acc_a, acc_b;
  logic        [CNT_W-1:0]     smp_cnt;
  logic        [7:0]           disc_cnt;
  logic signed [15:0]          dat_a, dat_b;
  logic                        valid, ovr_a, ovr_b;

  logic                        run_active, win_last;
  logic signed [ACC_W-1:0]     sum_a, sum_b, avg_a, avg_b;

  // A RUN cycle only counts while enable is still high, so a falling enable
  // on the final sample of a window never produces a strobe.
  assign run_active = (state == S_RUN) && bus.en_i;
  assign win_last   = run_active && (smp_cnt == CNT_LAST);

  // Window sum including the current sample; width covers 2^DEC_LOG2 extremes.
  assign sum_a = acc_a + ACC_W'(s2_a);
  assign sum_b = acc_b + ACC_W'(s2_b);
  assign avg_a = sum_a >>> DEC_LOG2;
  assign avg_b = sum_b >>> DEC_LOG2;

  // Two input stages: raw capture, then offset-binary to two's complement.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      raw_a <= '0;
      raw_b <= '0;
      s2_a  <= '0;
      s2_b  <= '0;
    end else begin
      raw_a <= bus.adc_dat_a_i;
      raw_b <= bus.adc_dat_b_i;
      s2_a  <= {raw_a[ADC_WIDTH-1], ~raw_a[ADC_WIDTH-2:0]};
      s2_b  <= {raw_b[ADC_WIDTH-1], ~raw_b[ADC_WIDTH-2:0]};
    end
  end

  // FSM state register.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; a low enable overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (!bus.en_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_DISCARD;
        S_DISCARD: if (disc_cnt == DISC_LAST) state_nxt = S_RUN;
        S_RUN:     state_nxt = S_RUN;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Settling counter, restarts from zero on every entry into DISCARD.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n)                           disc_cnt <= '0;
    else if (state == S_DISCARD && bus.en_i)  disc_cnt <= disc_cnt + 8'd1;
    else                                      disc_cnt <= '0;
  end

  // Accumulate and decimate; the partial window is dropped outside RUN.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      acc_a   <= '0;
      acc_b   <= '0;
      smp_cnt <= '0;
      dat_a   <= '0;
      dat_b   <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!run_active) begin
        acc_a   <= '0;
        acc_b   <= '0;
        smp_cnt <= '0;
      end else if (win_last) begin
        acc_a   <= '0;
        acc_b   <= '0;
        smp_cnt <= '0;
        dat_a   <= 16'(avg_a);
        dat_b   <= 16'(avg_b);
        valid   <= 1'b1;
      end else begin
        acc_a   <= sum_a;
        acc_b   <= sum_b;
        smp_cnt <= smp_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky overrange flags; a set in the same cycle as a clear wins.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      ovr_a <= 1'b0;
      ovr_b <= 1'b0;
    end else begin
      if (run_active && (s2_a == S2_MAX || s2_a == S2_MIN)) ovr_a <= 1'b1;
      else if (bus.ovr_clr_i)                               ovr_a <= 1'b0;
      if (run_active && (s2_b == S2_MAX || s2_b == S2_MIN)) ovr_b <= 1'b1;
      else if (bus.ovr_clr_i)                               ovr_b <= 1'b0;
    end
  end

  assign bus.adc_dat_a_o = dat_a;
  assign bus.adc_dat_b_o = dat_b;
  assign bus.adc_valid_o = valid;
  assign bus.ovr_a_o     = ovr_a;
  assign bus.ovr_b_o     = ovr_b;
  assign bus.adc_cdcs_o  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_redp_adc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_redp_adc
//  Purpose  : Self-checking bench for redp_adc. Two instances (no averaging
//             and 4-sample averaging) share the same stimulus and are both
//             compared every cycle against a sample-window reference model.
//  Revision : 1.0 - first release
// ============================================================================
module tb_redp_adc;

  localparam int DISC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [13:0] raw_a = '0, raw_b = '0;
  logic        en = 1'b0, ovr_clr = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  redp_adc_if #(.ADC_WIDTH(14)) if0 ();
  redp_adc_if #(.ADC_WIDTH(14)) if2 ();

  assign if0.adc_dat_a_i = raw_a;
  assign if0.adc_dat_b_i = raw_b;
  assign if0.en_i        = en;
  assign if0.ovr_clr_i   = ovr_clr;
  assign if2.adc_dat_a_i = raw_a;
  assign if2.adc_dat_b_i = raw_b;
  assign if2.en_i        = en;
  assign if2.ovr_clr_i   = ovr_clr;

  redp_adc #(.ADC_WIDTH(14), .DEC_LOG2(0), .DISCARD(DISC)) u_dec0 (
    .adc_clk(clk), .adc_rst_n(rst_n), .bus(if0));
  redp_adc #(.ADC_WIDTH(14), .DEC_LOG2(2), .DISCARD(DISC)) u_dec2 (
    .adc_clk(clk), .adc_rst_n(rst_n), .bus(if2));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          en_run;            // consecutive enabled edges since IDLE
  logic [13:0] hist_a[$], hist_b[$];
  int          sum_a[2], sum_b[2], cnt[2];
  int          exp_a[2], exp_b[2];
  logic        exp_v[2], exp_oa[2], exp_ob[2];

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    en_run = 0;
    hist_a.delete();
    hist_b.delete();
    for (int d = 0; d < 2; d++) begin
      sum_a[d] = 0; sum_b[d] = 0; cnt[d] = 0;
      exp_a[d] = 0; exp_b[d] = 0;
      exp_v[d] = 1'b0; exp_oa[d] = 1'b0; exp_ob[d] = 1'b0;
    end
  endtask

  // One clock edge: the sample reaching the averager is the pin value
  // captured two edges earlier; samples count once DISC settling cycles
  // have elapsed after the enable edge that left IDLE.
  task automatic model_edge(input logic e, input logic clr,
                            input logic [13:0] pa, input logic [13:0] pb);
    int  prior, sa, sb, len;
    bit  proc;
    prior = en_run;
    sa = (hist_a.size() >= 2) ? 8191 - int'(hist_a[hist_a.size()-2]) : 0;
    sb = (hist_b.size() >= 2) ? 8191 - int'(hist_b[hist_b.size()-2]) : 0;
    proc   = e && (prior >= DISC + 1);
    en_run = e ? prior + 1 : 0;
    for (int d = 0; d < 2; d++) begin
      len = (d == 0) ? 1 : 4;
      exp_v[d] = 1'b0;
      if (!e) begin
        sum_a[d] = 0; sum_b[d] = 0; cnt[d] = 0;
      end else if (proc) begin
        sum_a[d] += sa; sum_b[d] += sb; cnt[d]++;
        if (cnt[d] == len) begin
          exp_v[d] = 1'b1;
          exp_a[d] = floor_div(sum_a[d], len);
          exp_b[d] = floor_div(sum_b[d], len);
          sum_a[d] = 0; sum_b[d] = 0; cnt[d] = 0;
        end
      end
      if (proc && (sa == 8191 || sa == -8192)) exp_oa[d] = 1'b1;
      else if (clr)                            exp_oa[d] = 1'b0;
      if (proc && (sb == 8191 || sb == -8192)) exp_ob[d] = 1'b1;
      else if (clr)                            exp_ob[d] = 1'b0;
    end
    hist_a.push_back(pa);
    hist_b.push_back(pb);
    if (hist_a.size() > 3) begin
      void'(hist_a.pop_front());
      void'(hist_b.pop_front());
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid_dec0", 16'(if0.adc_valid_o), 16'(exp_v[0]));
    chk("dat_a_dec0", if0.adc_dat_a_o, 16'(exp_a[0]));
    chk("dat_b_dec0", if0.adc_dat_b_o, 16'(exp_b[0]));
    chk("ovr_a_dec0", 16'(if0.ovr_a_o), 16'(exp_oa[0]));
    chk("ovr_b_dec0", 16'(if0.ovr_b_o), 16'(exp_ob[0]));
    chk("cdcs_dec0",  16'(if0.adc_cdcs_o), 16'd1);
    chk("valid_dec2", 16'(if2.adc_valid_o), 16'(exp_v[1]));
    chk("dat_a_dec2", if2.adc_dat_a_o, 16'(exp_a[1]));
    chk("dat_b_dec2", if2.adc_dat_b_o, 16'(exp_b[1]));
    chk("ovr_a_dec2", 16'(if2.ovr_a_o), 16'(exp_oa[1]));
    chk("ovr_b_dec2", 16'(if2.ovr_b_o), 16'(exp_ob[1]));
    chk("cdcs_dec2",  16'(if2.adc_cdcs_o), 16'd1);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_v0"},  16'(if0.adc_valid_o), 16'd0);
    chk({tag, "_a0"},  if0.adc_dat_a_o, 16'd0);
    chk({tag, "_b0"},  if0.adc_dat_b_o, 16'd0);
    chk({tag, "_oa0"}, 16'(if0.ovr_a_o), 16'd0);
    chk({tag, "_ob0"}, 16'(if0.ovr_b_o), 16'd0);
    chk({tag, "_v2"},  16'(if2.adc_valid_o), 16'd0);
    chk({tag, "_a2"},  if2.adc_dat_a_o, 16'd0);
    chk({tag, "_b2"},  if2.adc_dat_b_o, 16'd0);
    chk({tag, "_oa2"}, 16'(if2.ovr_a_o), 16'd0);
    chk({tag, "_ob2"}, 16'(if2.ovr_b_o), 16'd0);
    chk({tag, "_cdcs"}, 16'(if0.adc_cdcs_o & if2.adc_cdcs_o), 16'd1);
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    @(posedge clk);
    model_edge(en, ovr_clr, raw_a, raw_b);
    @(negedge clk);
    check_all();
  endtask

  // ---------------- directed-run helpers ----------------
  logic [13:0] tab_a[int], tab_b[int];
  bit          clr_at[int];
  logic        rec_v0[0:63], rec_v2[0:63], rec_ob0[0:63], rec_ob2[0:63];
  logic [15:0] rec_a0[0:63], rec_a2[0:63];

  task automatic clear_tables();
    tab_a.delete(); tab_b.delete(); clr_at.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b0; ovr_clr = 1'b0;
      raw_a = 14'($urandom_range(1, 16382));
      raw_b = 14'($urandom_range(1, 16382));
      cycle();
    end
  endtask

  // Index j is the edge number counted from the enable edge that leaves IDLE.
  task automatic run_enabled(input int n);
    for (int j = 0; j < n; j++) begin
      en      = 1'b1;
      raw_a   = tab_a.exists(j) ? tab_a[j] : 14'($urandom_range(1, 16382));
      raw_b   = tab_b.exists(j) ? tab_b[j] : 14'($urandom_range(1, 16382));
      ovr_clr = clr_at.exists(j);
      cycle();
      rec_v0[j]  = if0.adc_valid_o;  rec_a0[j] = if0.adc_dat_a_o;
      rec_v2[j]  = if2.adc_valid_o;  rec_a2[j] = if2.adc_dat_a_o;
      rec_ob0[j] = if0.ovr_b_o;      rec_ob2[j] = if2.ovr_b_o;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    #1;
    check_reset_zero("reset_state");
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3);

    // Conversion sweep on channel A.
    clear_tables();
    tab_a[15] = 14'h0000; tab_a[16] = 14'h1FFF;
    tab_a[17] = 14'h2000; tab_a[18] = 14'h3FFF;
    run_enabled(22);
    for (int j = 0; j <= 16; j++) chk("no_strobe_discard_dec0", 16'(rec_v0[j]), 16'd0);
    chk("conv_0000_v", 16'(rec_v0[17]), 16'd1);
    chk("conv_0000",   rec_a0[17], 16'h1FFF);
    chk("conv_1fff",   rec_a0[18], 16'h0000);
    chk("conv_2000",   rec_a0[19], 16'hFFFF);
    chk("conv_3fff",   rec_a0[20], 16'hE000);
    chk("sweep_avg_v", 16'(rec_v2[20]), 16'd1);
    chk("sweep_avg",   rec_a2[20], 16'hFFFF);

    // Averaging: +3,+4,-2,-4 then -1,-1,-1,-2.
    idle(2);
    clear_tables();
    tab_a[15] = 14'd8188; tab_a[16] = 14'd8187; tab_a[17] = 14'd8193; tab_a[18] = 14'd8195;
    tab_a[19] = 14'd8192; tab_a[20] = 14'd8192; tab_a[21] = 14'd8192; tab_a[22] = 14'd8193;
    run_enabled(26);
    for (int j = 0; j < 20; j++) chk("avg_no_early_strobe", 16'(rec_v2[j]), 16'd0);
    chk("avg1_v", 16'(rec_v2[20]), 16'd1);
    chk("avg1",   rec_a2[20], 16'h0000);
    for (int j = 21; j < 24; j++) chk("avg_gap", 16'(rec_v2[j]), 16'd0);
    chk("avg2_v", 16'(rec_v2[24]), 16'd1);
    chk("avg2",   rec_a2[24], 16'hFFFE);

    // Abort after two RUN samples, then a fresh average of +4s.
    idle(2);
    clear_tables();
    tab_a[15] = 14'd8190; tab_a[16] = 14'd8190;
    run_enabled(19);
    for (int j = 0; j < 19; j++) chk("abort_no_strobe", 16'(rec_v2[j]), 16'd0);
    idle(3);
    clear_tables();
    for (int j = 15; j <= 18; j++) tab_a[j] = 14'd8187;
    run_enabled(21);
    for (int j = 0; j < 20; j++) chk("reenable_discard", 16'(rec_v2[j]), 16'd0);
    chk("reenable_avg_v", 16'(rec_v2[20]), 16'd1);
    chk("reenable_avg",   rec_a2[20], 16'h0004);

    // Overrange on channel B.
    idle(1);
    en = 1'b0; ovr_clr = 1'b1; cycle();
    chk("ovr_lone_clear_a0", 16'(if0.ovr_a_o), 16'd0);
    chk("ovr_lone_clear_b2", 16'(if2.ovr_b_o), 16'd0);
    clear_tables();
    tab_b[5] = 14'h3FFF; tab_b[15] = 14'h3FFF; tab_b[20] = 14'h3FFF;
    clr_at[22] = 1'b1; clr_at[25] = 1'b1;
    run_enabled(27);
    chk("ovr_discard_ignored", 16'(rec_ob2[16]), 16'd0);
    chk("ovr_discard_ign_d0",  16'(rec_ob0[10]), 16'd0);
    chk("ovr_set",             16'(rec_ob2[17]), 16'd1);
    chk("ovr_sticky",          16'(rec_ob2[21]), 16'd1);
    chk("ovr_set_wins",        16'(rec_ob2[22]), 16'd1);
    chk("ovr_set_wins_d0",     16'(rec_ob0[22]), 16'd1);
    chk("ovr_cleared",         16'(rec_ob2[25]), 16'd0);

    // Asynchronous reset in the middle of a run.
    idle(1);
    clear_tables();
    run_enabled(30);
    #3 rst_n = 1'b0;
    #1;
    check_reset_zero("async_reset");
    model_reset();
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    run_enabled(22);
    for (int j = 0; j < 20; j++) chk("post_reset_no_strobe", 16'(rec_v2[j]), 16'd0);
    chk("post_reset_strobe_dec2", 16'(rec_v2[20]), 16'd1);
    chk("post_reset_strobe_dec0", 16'(rec_v0[17]), 16'd1);

    // Randomized traffic: full raw range, sporadic enable drops and clears.
    en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      raw_a   = 14'($urandom_range(0, 16383));
      raw_b   = 14'($urandom_range(0, 16383));
      ovr_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/redp_adc.md
REDP_ADC -- requirements
Module: redp_adc

Interface
REQ-001 Parameter: ADC_WIDTH, 14, width of each raw ADC channel bus.
REQ-002 Parameter: DEC_LOG2, 0, log2 of the averaging/decimation ratio (legal range 0..4).
REQ-003 Parameter: DISCARD, 16, number of samples dropped after entering DISCARD (legal range 1..255).
REQ-004 Port: adc_clk  in  1  ADC sample clock; the block's only clock.
REQ-005 Port: adc_rst_n  in  1  reset, asynchronous and active-low.
REQ-006 Port: adc_dat_a_i  in  14  ADC IC channel A raw data, inverted offset binary.
REQ-007 Port: adc_dat_b_i  in  14  ADC IC channel B raw data, inverted offset binary.
REQ-008 Port: en_i  in  1  capture enable; level-sensitive.
REQ-009 Port: ovr_clr_i  in  1  one-cycle clear of both sticky overrange flags.
REQ-010 Port: adc_dat_a_o  out  16  channel A result, signed two's complement, sign-extended.
REQ-011 Port: adc_dat_b_o  out  16  channel B result, signed two's complement, sign-extended.
REQ-012 Port: adc_valid_o  out  1  one-cycle strobe qualifying both data outputs.
REQ-013 Port: ovr_a_o  out  1  sticky channel A overrange flag.
REQ-014 Port: ovr_b_o  out  1  sticky channel B overrange flag.
REQ-015 Port: adc_cdcs_o  out  1  ADC IC duty-cycle stabilizer enable; constant 1.

Function
REQ-016 Stage 1 SHALL register raw pins every cycle, unconditionally.
REQ-017 Stage 2 SHALL register the converted value {raw[13], ~raw[12:0]} as signed 14-bit.
- Examples: raw 0x0000 -> +8191; raw 0x1FFF -> 0; raw 0x2000 -> -1; raw 0x3FFF -> -8192.
REQ-018 The FSM SHALL have states IDLE, DISCARD and RUN.
- IDLE -> DISCARD when en_i=1.
- DISCARD -> RUN after DISCARD cycles counted.
- Any state -> IDLE when en_i=0, checked before all other transitions.
REQ-019 In IDLE and DISCARD: the accumulators and the sample counter SHALL be held at 0, adc_valid_o SHALL be 0, and the overrange flags SHALL NOT be set.
REQ-020 In RUN, each cycle the stage-2 value SHALL be added into a signed (14+DEC_LOG2)-bit per-channel accumulator, and the DEC_LOG2-bit sample counter SHALL increment, wrapping to 0.
REQ-021 On a RUN cycle with counter = 2^DEC_LOG2-1, at the same edge:
- output register <= (acc + stage2) arithmetically shifted right by DEC_LOG2 (floor), sign-extended to 16 bits;
- accumulator <= 0;
- adc_valid_o <= 1.
REQ-022 adc_valid_o SHALL be 0 on all other cycles; the data outputs SHALL hold their last value between strobes.
REQ-023 With DEC_LOG2=0, in RUN: adc_valid_o=1 every cycle, and the pin-to-output latency SHALL be 3 adc_clk edges.
REQ-024 With DEC_LOG2=N, the strobe period SHALL be exactly 2^N cycles, with the first strobe 2^N cycles after the first RUN cycle.
REQ-025 en_i falling mid-average SHALL discard the partial sum and emit no strobe for it; re-enabling SHALL restart DISCARD from 0.
REQ-026 In RUN, a stage-2 value of +8191 or -8192 SHALL set that channel's sticky flag on the next edge.
REQ-027 ovr_clr_i SHALL clear both flags; when set and clear coincide, set SHALL win.
REQ-028 No input combination SHALL cause accumulator overflow; the accumulator width covers the full 2^DEC_LOG2 range.

Reset
REQ-029 While adc_rst_n=0, all of the following SHALL hold asynchronously: FSM=IDLE, stage registers=0, accumulators=0, counters=0, adc_dat_a_o=adc_dat_b_o=0, adc_valid_o=0, ovr_a_o=ovr_b_o=0; adc_cdcs_o SHALL remain 1.
REQ-030 After adc_rst_n rises, with en_i=1 the FSM SHALL enter DISCARD on the first adc_clk edge.

Verification
REQ-031 Conversion, DEC_LOG2=0, DISCARD=16: en_i=1, raw A sweeps 0x0000/0x1FFF/0x2000/0x3FFF -> outputs +8191/0/-1/-8192 (0x1FFF/0x0000/0xFFFF/0xE000), each 3 edges after its pin cycle, with no strobe in the first 16 enabled cycles.
REQ-032 Averaging, DEC_LOG2=2: RUN with samples +3,+4,-2,-4 -> one strobe, output 0 (sum 1 >>2); samples -1,-1,-1,-2 -> output -2 (floor); strobes exactly 4 cycles apart.
REQ-033 Abort: DEC_LOG2=2, en_i dropped after 2 RUN samples -> no strobe; re-enable -> 16 discard cycles, then a fresh 4-sample average unaffected by the old partial sum.
REQ-034 Overrange: raw B=0x3FFF for one RUN cycle -> ovr_b_o=1 and stays 1; ovr_clr_i coinciding with a second 0x3FFF -> flag remains 1; a lone ovr_clr_i -> 0; the same raw value during DISCARD -> flag stays 0.
REQ-035 Reset mid-run: adc_rst_n low between clock edges -> all outputs 0 immediately; release with en_i=1 -> DISCARD restarts and the first strobe follows 16+2^DEC_LOG2 cycles after the FSM leaves IDLE.
